// File: rtl/spi_loopback_core.sv
// spi_loopback_core: baud generator, SPI master and SPI slave joined back-to-back
// through internal mosi/miso/sck/ss_b. One request exchanges one 8-bit word
// full-duplex in any CPOL/CPHA mode, MSB- or LSB-first.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   SPI_RDY    level-sensitive transfer request, sampled in IDLE
//   LSBFE      1 = LSB first, 0 = MSB first
//   sppr, spr  baud select: half SCK period H = (sppr+1) << spr clk cycles
//   cpol       SCK idle level
//   cpha       0 = sample on leading edge, 1 = sample on trailing edge
//   Data_in_m  word sent by the master
//   Data_in_s  word sent by the slave
//   Data_out_m last word received by the master
//   Data_out_s last word received by the slave
//   c          one-cycle transfer-complete pulse
module spi_loopback_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       SPI_RDY,
    input  logic       LSBFE,
    input  logic [2:0] sppr,
    input  logic [2:0] spr,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] Data_in_m,
    input  logic [7:0] Data_in_s,
    output logic [7:0] Data_out_m,
    output logic [7:0] Data_out_s,
    output logic       c
);

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned EDGE_W    = 5;
    localparam int unsigned BAUD_W    = 10;
    localparam int unsigned HALF_W    = 11;
    localparam int unsigned LAST_EDGE = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic                sck;
    logic                ss_b;

    // Configuration frozen at the start of each word
    logic                cpol_q;
    logic                cpha_q;
    logic                lsbfe_q;
    logic [2:0]          sppr_q;
    logic [2:0]          spr_q;

    logic [WORD_W-1:0]   m_tx;
    logic [WORD_W-1:0]   m_rx;
    logic [WORD_W-1:0]   s_tx;
    logic [WORD_W-1:0]   s_rx;

    logic [HALF_W-1:0]   half_c;
    logic [BAUD_W-1:0]   half_m1_c;
    logic                tick_c;
    logic [EDGE_W-1:0]   next_edge_c;
    logic                lead_c;
    logic                sample_c;
    logic                shift_c;
    logic                mosi;
    logic                miso;

    function automatic logic [WORD_W-1:0] rx_shift(input logic [WORD_W-1:0] r,
                                                   input logic b,
                                                   input logic lsb_first);
        return lsb_first ? {b, r[WORD_W-1:1]} : {r[WORD_W-2:0], b};
    endfunction

    function automatic logic [WORD_W-1:0] tx_shift(input logic [WORD_W-1:0] r,
                                                   input logic lsb_first);
        return lsb_first ? {1'b0, r[WORD_W-1:1]} : {r[WORD_W-2:0], 1'b0};
    endfunction

    // Baud tick, edge classification and serial lines
    always_comb begin
        half_c      = HALF_W'({1'b0, sppr_q} + 4'd1) << spr_q;
        half_m1_c   = BAUD_W'(half_c - HALF_W'(1));
        tick_c      = (state != IDLE) && (baud_cnt == half_m1_c);
        next_edge_c = edge_cnt + EDGE_W'(1);
        lead_c      = next_edge_c[0];
        sample_c    = cpha_q ? ~lead_c : lead_c;
        // With CPHA=1 edge 1 only exposes the first bit already sitting at the output
        shift_c     = cpha_q ? (lead_c && (next_edge_c != EDGE_W'(1))) : ~lead_c;
        mosi        = lsbfe_q ? m_tx[0] : m_tx[WORD_W-1];
        miso        = lsbfe_q ? s_tx[0] : s_tx[WORD_W-1];
    end

    // Master FSM, baud counter and slave datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            edge_cnt   <= '0;
            sck        <= cpol;
            ss_b       <= 1'b1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            sppr_q     <= '0;
            spr_q      <= '0;
            m_tx       <= '0;
            m_rx       <= '0;
            s_tx       <= '0;
            s_rx       <= '0;
            Data_out_m <= '0;
            Data_out_s <= '0;
            c          <= 1'b0;
        end else begin
            c <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    sck      <= cpol;
                    ss_b     <= 1'b1;
                    if (SPI_RDY) begin
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsbfe_q  <= LSBFE;
                        sppr_q   <= sppr;
                        spr_q    <= spr;
                        m_tx     <= Data_in_m;
                        m_rx     <= '0;
                        // Slave loads on the same edge that drives SS_b low
                        s_tx     <= Data_in_s;
                        s_rx     <= '0;
                        edge_cnt <= '0;
                        ss_b     <= 1'b0;
                        state    <= XFER;
                    end
                end

                XFER: begin
                    baud_cnt <= tick_c ? '0 : baud_cnt + BAUD_W'(1);
                    if (tick_c) begin
                        if (edge_cnt == EDGE_W'(LAST_EDGE)) begin
                            sck        <= cpol_q;
                            ss_b       <= 1'b1;
                            Data_out_m <= m_rx;
                            Data_out_s <= s_rx;
                            c          <= 1'b1;
                            edge_cnt   <= '0;
                            state      <= GAP;
                        end else begin
                            edge_cnt <= next_edge_c;
                            sck      <= ~sck;
                            if (sample_c) begin
                                m_rx <= rx_shift(m_rx, miso, lsbfe_q);
                                if (!ss_b) begin
                                    s_rx <= rx_shift(s_rx, mosi, lsbfe_q);
                                end
                            end
                            if (shift_c) begin
                                m_tx <= tx_shift(m_tx, lsbfe_q);
                                if (!ss_b) begin
                                    s_tx <= tx_shift(s_tx, lsbfe_q);
                                end
                            end
                        end
                    end
                end

                GAP: begin
                    baud_cnt <= tick_c ? '0 : baud_cnt + BAUD_W'(1);
                    if (tick_c) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_loopback_core.sv
// Directed testbench for spi_loopback_core: reset, mode 0 reference word,
// all CPOL/CPHA/LSBFE combinations, baud divider, back-to-back words,
// request drop mid-word and reset mid-word.
module tb_spi_loopback_core;

    logic       clk;
    logic       rst;
    logic       SPI_RDY;
    logic       LSBFE;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       cpol;
    logic       cpha;
    logic [7:0] Data_in_m;
    logic [7:0] Data_in_s;
    logic [7:0] Data_out_m;
    logic [7:0] Data_out_s;
    logic       c;

    int n_checks;
    int n_fail;

    spi_loopback_core dut (
        .clk        (clk),
        .rst        (rst),
        .SPI_RDY    (SPI_RDY),
        .LSBFE      (LSBFE),
        .sppr       (sppr),
        .spr        (spr),
        .cpol       (cpol),
        .cpha       (cpha),
        .Data_in_m  (Data_in_m),
        .Data_in_s  (Data_in_s),
        .Data_out_m (Data_out_m),
        .Data_out_s (Data_out_s),
        .c          (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for c; n = cycles counted until c seen, -1 on timeout
    task automatic wait_c(input int limit, output int n);
        int k;
        k = 0;
        n = -1;
        while (k < limit && n < 0) begin
            step();
            k++;
            if (c === 1'b1) n = k;
        end
    endtask

    task automatic count_c(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (c === 1'b1) n++;
        end
    endtask

    // One complete word; records latency from start edge, SCK activity and MOSI at sample edges
    task automatic run_xfer(input logic [7:0] dm, input logic [7:0] ds, input logic lsb,
                            input logic pol, input logic pha, input logic [2:0] pp,
                            input logic [2:0] sp, output int lat, output logic [7:0] rec,
                            output logic first_bit, output int nedge, output int min_iv,
                            output int max_iv, output logic idle_ok);
        logic prev;
        int   last;
        int   nsamp;
        bit   got;
        Data_in_m = dm; Data_in_s = ds; LSBFE = lsb; cpol = pol; cpha = pha;
        sppr = pp; spr = sp; SPI_RDY = 1'b0;
        repeat (8) step();
        idle_ok = (dut.sck === pol) && (dut.ss_b === 1'b1);
        SPI_RDY = 1'b1;
        step();
        SPI_RDY = 1'b0;
        lat = 0; prev = dut.sck; last = 0; nedge = 0; nsamp = 0;
        rec = 8'h00; first_bit = 1'b0; min_iv = 1000000; max_iv = 0; got = 1'b0;
        while (lat < 5000 && !got) begin
            step();
            lat++;
            if (dut.sck !== prev) begin
                nedge++;
                if (lat - last < min_iv) min_iv = lat - last;
                if (lat - last > max_iv) max_iv = lat - last;
                last = lat;
                if ((pha == 1'b0 && nedge % 2 == 1) || (pha == 1'b1 && nedge % 2 == 0)) begin
                    if (nsamp == 0) first_bit = dut.mosi;
                    nsamp++;
                    rec = lsb ? {dut.mosi, rec[7:1]} : {rec[6:0], dut.mosi};
                end
            end
            prev = dut.sck;
            if (c === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL xfer_timeout: no c after %0d cycles, required within 5000", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; SPI_RDY = 1'b0; cpol = 1'b1; cpha = 1'b0; LSBFE = 1'b0;
        sppr = 3'd0; spr = 3'd0; Data_in_m = 8'h00; Data_in_s = 8'h00;
        repeat (10) step();
        n_checks++; if (Data_out_m !== 8'h00) begin n_fail++; $display("FAIL reset_dout_m: got %h expected 00", Data_out_m); end
        n_checks++; if (Data_out_s !== 8'h00) begin n_fail++; $display("FAIL reset_dout_s: got %h expected 00", Data_out_s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL reset_c: got %b expected 0", c); end
        n_checks++; if (dut.ss_b !== 1'b1) begin n_fail++; $display("FAIL reset_ss_b: got %b expected 1", dut.ss_b); end
        n_checks++; if (dut.sck !== 1'b1) begin n_fail++; $display("FAIL reset_sck: got %b expected 1", dut.sck); end
        rst = 1'b0; cpol = 1'b0;
        step();
        n_checks++; if (dut.sck !== 1'b0) begin n_fail++; $display("FAIL idle_sck_follows_cpol: got %b expected 0", dut.sck); end
    endtask

    task automatic test_mode0();
        int lat, ne, mn, mx; logic [7:0] rec; logic fb, ok;
        run_xfer(8'hB4, 8'h97, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, lat, rec, fb, ne, mn, mx, ok);
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL mode0_latency: got %0d expected 17", lat); end
        n_checks++; if (Data_out_m !== 8'h97) begin n_fail++; $display("FAIL mode0_dout_m: got %h expected 97", Data_out_m); end
        n_checks++; if (Data_out_s !== 8'hB4) begin n_fail++; $display("FAIL mode0_dout_s: got %h expected b4", Data_out_s); end
        // MOSI sequence 1,0,1,1,0,1,0,0 assembled MSB first
        n_checks++; if (rec !== 8'hB4) begin n_fail++; $display("FAIL mode0_mosi_seq: got %h expected b4", rec); end
        n_checks++; if (ne !== 16) begin n_fail++; $display("FAIL mode0_edges: got %0d expected 16", ne); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mode0_idle: got %b expected 1", ok); end
        step();
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL mode0_c_width: got %b expected 0", c); end
    endtask

    // 0xA5/0x3C are bit-reversal symmetric, so a second non-symmetric pair exposes bit order
    task automatic test_all_modes();
        int lat, ne, mn, mx; logic [7:0] rec; logic fb, ok;
        logic [7:0] dm, ds; logic [2:0] sel;
        for (int p = 0; p < 2; p++) begin
            dm = (p == 0) ? 8'hA5 : 8'h1D;
            ds = (p == 0) ? 8'h3C : 8'hB2;
            for (int i = 0; i < 8; i++) begin
                sel = 3'(i);
                run_xfer(dm, ds, sel[2], sel[1], sel[0], 3'd0, 3'd0, lat, rec, fb, ne, mn, mx, ok);
                n_checks++; if (Data_out_m !== ds) begin n_fail++; $display("FAIL modes_dout_m[%0d]: got %h expected %h", i, Data_out_m, ds); end
                n_checks++; if (Data_out_s !== dm) begin n_fail++; $display("FAIL modes_dout_s[%0d]: got %h expected %h", i, Data_out_s, dm); end
                n_checks++; if (rec !== dm) begin n_fail++; $display("FAIL modes_mosi[%0d]: got %h expected %h", i, rec, dm); end
                n_checks++; if (fb !== (sel[2] ? dm[0] : dm[7])) begin n_fail++; $display("FAIL modes_first_bit[%0d]: got %b expected %b", i, fb, sel[2] ? dm[0] : dm[7]); end
                n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL modes_sck_idle[%0d]: got %b expected 1", i, ok); end
                n_checks++; if (lat !== 17 || ne !== 16) begin n_fail++; $display("FAIL modes_timing[%0d]: got lat %0d edges %0d expected 17/16", i, lat, ne); end
            end
        end
    endtask

    task automatic test_divider();
        int lat, ne, mn, mx; logic [7:0] rec; logic fb, ok;
        run_xfer(8'h81, 8'h7E, 1'b0, 1'b1, 1'b0, 3'd2, 3'd1, lat, rec, fb, ne, mn, mx, ok);
        n_checks++; if (lat !== 102) begin n_fail++; $display("FAIL div_latency: got %0d expected 102", lat); end
        n_checks++; if (mn !== 6 || mx !== 6) begin n_fail++; $display("FAIL div_phase: got min %0d max %0d expected 6/6", mn, mx); end
        n_checks++; if (ne !== 16) begin n_fail++; $display("FAIL div_edges: got %0d expected 16", ne); end
        n_checks++; if (Data_out_m !== 8'h7E || Data_out_s !== 8'h81) begin n_fail++; $display("FAIL div_data: got %h/%h expected 7e/81", Data_out_m, Data_out_s); end
        step();
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL div_c_width: got %b expected 0", c); end
    endtask

    task automatic test_back_to_back();
        int n1, n2, npulse;
        Data_in_m = 8'h11; Data_in_s = 8'hEE; LSBFE = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = 3'd0; spr = 3'd0; SPI_RDY = 1'b0;
        repeat (10) step();
        SPI_RDY = 1'b1;
        step();
        wait_c(100, n1);
        n_checks++; if (n1 !== 17) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 17", n1); end
        n_checks++; if (Data_out_m !== 8'hEE || Data_out_s !== 8'h11) begin n_fail++; $display("FAIL b2b_first_data: got %h/%h expected ee/11", Data_out_m, Data_out_s); end
        Data_in_m = 8'h22; Data_in_s = 8'hDD;
        step();
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL b2b_c_width: got %b expected 0", c); end
        step();
        SPI_RDY = 1'b0;
        n_checks++; if (dut.ss_b !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got ss_b %b expected 0", dut.ss_b); end
        wait_c(100, n2);
        n_checks++; if (n2 !== 17) begin n_fail++; $display("FAIL b2b_period: got %0d expected 17 (19 total)", n2); end
        n_checks++; if (Data_out_m !== 8'hDD || Data_out_s !== 8'h22) begin n_fail++; $display("FAIL b2b_second_data: got %h/%h expected dd/22", Data_out_m, Data_out_s); end
        count_c(60, npulse);
        n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL b2b_extra_c: got %0d expected 0", npulse); end
    endtask

    task automatic test_rdy_drop();
        int n, npulse;
        Data_in_m = 8'h4E; Data_in_s = 8'hD3; LSBFE = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = 3'd0; spr = 3'd0; SPI_RDY = 1'b0;
        repeat (8) step();
        SPI_RDY = 1'b1;
        step();
        repeat (5) step();
        // Request, data and config all change at edge 5; the word in flight must be unaffected
        SPI_RDY = 1'b0; Data_in_m = 8'hFF; Data_in_s = 8'h00; LSBFE = 1'b1; cpha = 1'b1;
        wait_c(100, n);
        n_checks++; if (n !== 12) begin n_fail++; $display("FAIL drop_latency: got %0d expected 12", n); end
        n_checks++; if (Data_out_m !== 8'hD3 || Data_out_s !== 8'h4E) begin n_fail++; $display("FAIL drop_data: got %h/%h expected d3/4e", Data_out_m, Data_out_s); end
        count_c(60, npulse);
        n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL drop_extra_c: got %0d expected 0", npulse); end
        n_checks++; if (dut.ss_b !== 1'b1) begin n_fail++; $display("FAIL drop_ss_b: got %b expected 1", dut.ss_b); end
    endtask

    task automatic test_reset_mid();
        int npulse, lat, ne, mn, mx; logic [7:0] rec; logic fb, ok;
        Data_in_m = 8'h5A; Data_in_s = 8'hC3; LSBFE = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = 3'd0; spr = 3'd0; SPI_RDY = 1'b0;
        repeat (8) step();
        SPI_RDY = 1'b1;
        step();
        SPI_RDY = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        n_checks++; if (Data_out_m !== 8'h00 || Data_out_s !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h/%h expected 00/00", Data_out_m, Data_out_s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL rstmid_c: got %b expected 0", c); end
        n_checks++; if (dut.ss_b !== 1'b1 || dut.sck !== 1'b0) begin n_fail++; $display("FAIL rstmid_lines: got ss_b %b sck %b expected 1/0", dut.ss_b, dut.sck); end
        rst = 1'b0;
        count_c(30, npulse);
        n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL rstmid_no_c: got %0d expected 0", npulse); end
        run_xfer(8'h69, 8'h96, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, lat, rec, fb, ne, mn, mx, ok);
        n_checks++; if (Data_out_m !== 8'h96 || Data_out_s !== 8'h69) begin n_fail++; $display("FAIL rstmid_after_data: got %h/%h expected 96/69", Data_out_m, Data_out_s); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d expected 17", lat); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mode0();
        test_all_modes();
        test_divider();
        test_back_to_back();
        test_rdy_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
